// File: rtl/soundweb_pkg.sv
// rtl/soundweb_pkg.sv - Soundweb framing constants and types shared by the encoder and decoder
package soundweb_pkg;

  localparam logic [7:0] STX        = 8'h02;
  localparam logic [7:0] ETX        = 8'h03;
  localparam logic [7:0] ACK        = 8'h06;
  localparam logic [7:0] NAK        = 8'h15;
  localparam logic [7:0] ESC        = 8'h1B;
  localparam logic [7:0] ESC_OFFSET = 8'h80;

  localparam int PAYLOAD_LEN = 13;
  localparam int FRAME_LEN   = 14;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BODY,
    S_ESC
  } state_t;

  // Only the five reserved byte values may appear in escaped form on the wire
  function automatic logic is_escaped_code(input logic [7:0] b);
    return (b == (STX + ESC_OFFSET)) || (b == (ETX + ESC_OFFSET)) ||
           (b == (ACK + ESC_OFFSET)) || (b == (NAK + ESC_OFFSET)) ||
           (b == (ESC + ESC_OFFSET));
  endfunction

endpackage

// File: rtl/soundweb_unescape.sv
// rtl/soundweb_unescape.sv - Byte-stuffing removal: escape detection, validation and unescaped byte strobe
module soundweb_unescape
  import soundweb_pkg::*;
(
  input  logic       in_valid,
  input  logic [7:0] in_byte,
  input  logic       in_body,
  input  logic       in_esc,
  output logic       esc_start,
  output logic       byte_valid,
  output logic [7:0] byte_out,
  output logic       esc_error
);

  always_comb begin
    esc_start  = 1'b0;
    byte_valid = 1'b0;
    byte_out   = in_byte;
    esc_error  = 1'b0;
    if (in_valid && in_esc) begin
      if (is_escaped_code(in_byte)) begin
        byte_valid = 1'b1;
        byte_out   = in_byte - ESC_OFFSET;
      end else begin
        esc_error = 1'b1;
      end
    end else if (in_valid && in_body) begin
      // Framing bytes are consumed by the top; everything else is payload
      if (in_byte == ESC) begin
        esc_start = 1'b1;
      end else if (in_byte != STX && in_byte != ETX) begin
        byte_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/soundweb_decoder.sv
// rtl/soundweb_decoder.sv - Receive-side Soundweb framer: STX/ETX detection, unstuffing, XOR check, field output
module soundweb_decoder
  import soundweb_pkg::*;
#(
  parameter int TIMEOUT       = 50000,
  parameter int TIMEOUT_WIDTH = 16
) (
  input  logic        fpga_clk_50,
  input  logic        hps_fpga_reset_n,
  input  logic        in_valid,
  input  logic [7:0]  in_byte,
  output logic        rx_valid,
  output logic [7:0]  command,
  output logic [47:0] address,
  output logic [15:0] sv,
  output logic [31:0] data,
  output logic        ack_rx,
  output logic        nak_rx,
  output logic        err_checksum,
  output logic        err_length,
  output logic        err_escape,
  output logic        err_timeout
);

  state_t                   state, state_next;
  logic [TIMEOUT_WIDTH-1:0] gap_cnt;
  logic [3:0]               count;
  logic [7:0]               xor_acc, chk_byte;
  logic [PAYLOAD_LEN*8-1:0] shadow;

  logic       esc_start, byte_valid, esc_error;
  logic [7:0] byte_out;
  logic       in_frame, timeout_hit, stx_seen, etx_seen, overflow, store, frame_full;
  logic       rx_valid_d, ack_d, nak_d, err_chk_d, err_len_d, err_esc_d, err_to_d;

  soundweb_unescape u_unescape (
    .in_valid  (in_valid),
    .in_byte   (in_byte),
    .in_body   (state == S_BODY),
    .in_esc    (state == S_ESC),
    .esc_start (esc_start),
    .byte_valid(byte_valid),
    .byte_out  (byte_out),
    .esc_error (esc_error)
  );

  assign in_frame    = (state != S_IDLE);
  assign timeout_hit = in_frame && !in_valid && (gap_cnt == TIMEOUT_WIDTH'(TIMEOUT - 1));
  assign stx_seen    = in_valid && (in_byte == STX) && (state != S_ESC);
  assign etx_seen    = in_valid && (in_byte == ETX) && (state == S_BODY);
  assign frame_full  = (count == 4'(FRAME_LEN));
  assign overflow    = byte_valid && frame_full;
  assign store       = byte_valid && !frame_full;

  always_ff @(posedge fpga_clk_50 or negedge hps_fpga_reset_n) begin
    if (!hps_fpga_reset_n) state <= S_IDLE;
    else                   state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (stx_seen) state_next = S_BODY;
      S_BODY: begin
        if (timeout_hit || etx_seen || overflow) state_next = S_IDLE;
        else if (esc_start)                      state_next = S_ESC;
      end
      S_ESC: begin
        if (timeout_hit || esc_error || overflow) state_next = S_IDLE;
        else if (byte_valid)                      state_next = S_BODY;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    ack_d      = (state == S_IDLE) && in_valid && (in_byte == ACK);
    nak_d      = (state == S_IDLE) && in_valid && (in_byte == NAK);
    err_esc_d  = esc_error;
    err_to_d   = timeout_hit;
    err_len_d  = overflow || ((state == S_BODY) && stx_seen) || (etx_seen && !frame_full);
    err_chk_d  = etx_seen && frame_full && (xor_acc != chk_byte);
    rx_valid_d = etx_seen && frame_full && (xor_acc == chk_byte);
  end

  // Payload shifts in MSB first so the field slices fall out of fixed bit positions
  always_ff @(posedge fpga_clk_50 or negedge hps_fpga_reset_n) begin
    if (!hps_fpga_reset_n) begin
      gap_cnt  <= '0;
      count    <= '0;
      xor_acc  <= '0;
      chk_byte <= '0;
      shadow   <= '0;
    end else begin
      if (in_valid || timeout_hit) gap_cnt <= '0;
      else if (in_frame)           gap_cnt <= gap_cnt + 1'b1;

      if (stx_seen) begin
        count   <= '0;
        xor_acc <= '0;
      end else if (store) begin
        count <= count + 4'd1;
        if (count == 4'(PAYLOAD_LEN)) begin
          chk_byte <= byte_out;
        end else begin
          shadow  <= {shadow[PAYLOAD_LEN*8-9:0], byte_out};
          xor_acc <= xor_acc ^ byte_out;
        end
      end
    end
  end

  always_ff @(posedge fpga_clk_50 or negedge hps_fpga_reset_n) begin
    if (!hps_fpga_reset_n) begin
      rx_valid     <= 1'b0;
      ack_rx       <= 1'b0;
      nak_rx       <= 1'b0;
      err_checksum <= 1'b0;
      err_length   <= 1'b0;
      err_escape   <= 1'b0;
      err_timeout  <= 1'b0;
      command      <= '0;
      address      <= '0;
      sv           <= '0;
      data         <= '0;
    end else begin
      rx_valid     <= rx_valid_d;
      ack_rx       <= ack_d;
      nak_rx       <= nak_d;
      err_checksum <= err_chk_d;
      err_length   <= err_len_d;
      err_escape   <= err_esc_d;
      err_timeout  <= err_to_d;
      if (rx_valid_d) begin
        command <= shadow[103:96];
        address <= shadow[95:48];
        sv      <= shadow[47:32];
        data    <= shadow[31:0];
      end
    end
  end

endmodule
